mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory bus port between instruction fetch (IF) and data access (MEM).
- Sequences one bus transaction at a time and returns each response to the requester that issued it.
- Drives per-requester stall lines that the pipeline control logic ORs into its PC and pipeline-register stall controls.
- Discards fetch responses that are made stale by a taken branch (flush).

Parameters:
- XLEN, 32: address and data width.
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before the transaction is force-completed with an error.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  taken branch in EX: kill the outstanding or pending fetch.
- if_req_valid  in  1  fetch request; held high until if_resp_valid.
- if_req_addr  in  XLEN  fetch address.
- if_resp_valid  out  1  one-cycle pulse: fetch data valid.
- if_resp_rdata  out  XLEN  fetched instruction.
- if_resp_err  out  1  fetch bus error or timeout; qualified by if_resp_valid.
- if_stall  out  1  fetch waiting for the port.
- dm_req_valid  in  1  data request; held high until dm_resp_valid.
- dm_req_we  in  1  1 = store.
- dm_req_addr  in  XLEN  data address.
- dm_req_wdata  in  XLEN  store data.
- dm_req_be  in  XLEN/8  byte enables.
- dm_resp_valid  out  1  one-cycle pulse: data access complete.
- dm_resp_rdata  out  XLEN  load data.
- dm_resp_err  out  1  data bus error or timeout; qualified by dm_resp_valid.
- dm_stall  out  1  data access waiting for the port.
- bus_req_valid  out  1  request to memory.
- bus_req_ready  in  1  memory accepts the request.
- bus_req_we, bus_req_addr, bus_req_wdata, bus_req_be  out  1/XLEN/XLEN/XLEN/8  latched request fields.
- bus_resp_valid  in  1  memory response strobe.
- bus_resp_rdata  in  XLEN  response data.
- bus_resp_err  in  1  memory error flag.

Behaviour:
Reset
- All registered outputs are 0; state = IDLE; owner = OWN_IF; timeout counter = 0; latched request fields = 0.
- Reset mid-transaction returns to IDLE. A bus_resp_valid arriving afterwards is ignored because IDLE ignores responses.

States
- IDLE: if dm_req_valid, latch the DM request and set owner = OWN_DM. Otherwise, if if_req_valid && !flush, latch the IF request (we = 0, be = all ones) and set owner = OWN_IF. On either grant, go to REQ. DM always has priority over IF.
- REQ: bus_req_valid = 1 from registered state, with latched fields stable. When bus_req_ready = 1, go to WAIT and clear the counter. A request is never withdrawn once bus_req_valid is high.
- WAIT: the counter increments every cycle.
  - On bus_resp_valid, pulse owner resp_valid for the same cycle. Resp data and err are combinational pass-through of bus_resp_rdata and bus_resp_err. Then go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES first, pulse owner resp_valid with resp_err = 1 and rdata = 0, then go to IDLE.
- DRAIN: the killed fetch is still outstanding. Wait for bus_resp_valid or timeout, give no response to IF, then go to IDLE.

Flush
- Owner IF in WAIT: go to DRAIN next cycle. A response arriving in the flush cycle itself is suppressed and the FSM goes to IDLE.
- Owner IF in REQ: set a kill flag. On acceptance, go to DRAIN instead of WAIT.
- Owner DM: flush has no effect.
- In IDLE: flush blocks the IF grant for that cycle only.

Stalls (combinational)
- if_stall = if_req_valid && !if_resp_valid.
- dm_stall = dm_req_valid && !dm_resp_valid.

Latency and throughput
- Minimum latency: request seen in IDLE at cycle 0, REQ at cycle 1 with ready = 1, response at cycle 2. The response is returned in cycle 2.
- One IDLE cycle separates consecutive transactions, giving at most 1 transaction per 3 cycles.

Simultaneous requests
- IF and DM requesting together in IDLE: DM is granted and IF stalls.
- IF starvation is impossible because the in-order pipeline issues at most one DM request per instruction.

Decomposition:
- riscv_pkg gains:
  - typedef enum arb_state_t {IDLE, REQ, WAIT, DRAIN};
  - typedef enum arb_owner_t {OWN_IF, OWN_DM};
  - typedef struct mem_req_t {we, addr, wdata, be};
  - constant MEM_TIMEOUT_DEFAULT.
- No sub-module. The FSM, request latch and counter form one module.

Test Plan:
- IF alone, addr 0x100, memory ready immediately, responds 1 cycle later with 0x00000013 -> if_resp_valid pulse in cycle 2 with rdata 0x13; if_stall high in cycles 0-1.
- IF and DM valid together, DM store addr 0x2000 wdata 0xDEADBEEF be 0xF -> DM transaction issues first (bus_req_we = 1); IF is issued after dm_resp_valid plus 1 IDLE cycle.
- IF in WAIT and flush asserted, memory responds 3 cycles later -> no if_resp_valid, state returns to IDLE; the next IF request (addr 0x200) is serviced normally.
- bus_req_ready held low for 5 cycles -> bus_req_valid and latched fields stay stable all 5 cycles; WAIT is entered on the ready cycle.
- No response with TIMEOUT_CYCLES = 4 -> dm_resp_valid with dm_resp_err = 1 and rdata = 0 on the 4th WAIT cycle; bus_resp_err = 1 on a normal response is forwarded as resp_err.
- rst asserted during WAIT, followed by a stray bus_resp_valid -> no resp pulses, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the unified memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, REQ, WAIT, DRAIN)
//   arb_owner_t : which requester owns the current bus transaction
//   mem_req_t   : latched bus request fields at the default data width
//   MEM_TIMEOUT_DEFAULT : default WAIT-state timeout in cycles
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int MEM_XLEN            = 32;
  localparam int MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic                    we;
    logic [MEM_XLEN-1:0]     addr;
    logic [MEM_XLEN-1:0]     wdata;
    logic [MEM_XLEN/8-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every non-clock/reset signal of the memory port arbiter.
//   flush                 : taken-branch kill of the fetch in flight
//   if_req_* / if_resp_*  : instruction fetch request/response + if_stall
//   dm_req_* / dm_resp_*  : data access request/response + dm_stall
//   bus_req_* / bus_resp_*: the single shared memory bus
// Modports:
//   master : the arbiter (bus master; serves the pipeline requesters)
//   slave  : the environment (pipeline requesters and the memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
) ();

  logic                flush;

  logic                if_req_valid;
  logic [XLEN-1:0]     if_req_addr;
  logic                if_resp_valid;
  logic [XLEN-1:0]     if_resp_rdata;
  logic                if_resp_err;
  logic                if_stall;

  logic                dm_req_valid;
  logic                dm_req_we;
  logic [XLEN-1:0]     dm_req_addr;
  logic [XLEN-1:0]     dm_req_wdata;
  logic [XLEN/8-1:0]   dm_req_be;
  logic                dm_resp_valid;
  logic [XLEN-1:0]     dm_resp_rdata;
  logic                dm_resp_err;
  logic                dm_stall;

  logic                bus_req_valid;
  logic                bus_req_ready;
  logic                bus_req_we;
  logic [XLEN-1:0]     bus_req_addr;
  logic [XLEN-1:0]     bus_req_wdata;
  logic [XLEN/8-1:0]   bus_req_be;
  logic                bus_resp_valid;
  logic [XLEN-1:0]     bus_resp_rdata;
  logic                bus_resp_err;

  modport master (
    input  flush,
    input  if_req_valid, if_req_addr,
    output if_resp_valid, if_resp_rdata, if_resp_err, if_stall,
    input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_be,
    output dm_resp_valid, dm_resp_rdata, dm_resp_err, dm_stall,
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_be,
    input  bus_req_ready,
    input  bus_resp_valid, bus_resp_rdata, bus_resp_err
  );

  modport slave (
    output flush,
    output if_req_valid, if_req_addr,
    input  if_resp_valid, if_resp_rdata, if_resp_err, if_stall,
    output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_be,
    input  dm_resp_valid, dm_resp_rdata, dm_resp_err, dm_stall,
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_be,
    output bus_req_ready,
    output bus_resp_valid, bus_resp_rdata, bus_resp_err
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory bus port between instruction fetch (IF) and data access
// (DM). One transaction at a time: IDLE grants (DM first), REQ presents the
// latched request until accepted, WAIT returns the response to its owner,
// DRAIN swallows the response of a fetch killed by a taken branch.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   port : mem_port_arbiter_if.master (requesters, stalls, memory bus)
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN           = MEM_XLEN,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.master port
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_REQ   = REQ;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_DRAIN = DRAIN;

  // The counter is cleared on acceptance, so the last WAIT cycle before the
  // forced completion is the one where it still reads TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef struct packed {
    logic                we;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     wdata;
    logic [XLEN/8-1:0]   be;
  } req_t;

  localparam req_t REQ_ZERO = req_t'(0);

  logic [1:0]         state_q, state_d;
  arb_owner_t         owner_q, owner_d;
  logic               kill_q, kill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_t               req_q, req_d;
  logic               bus_req_valid_q, bus_req_valid_d;

  logic               timeout_s;
  logic               fetch_flush_s;
  logic               kill_now_s;
  logic               fire_s;
  logic               if_resp_valid_s;
  logic               dm_resp_valid_s;
  logic [XLEN-1:0]    resp_rdata_s;
  logic               resp_err_s;

  // Timeout and flush qualifiers shared by the FSM
  always_comb begin
    timeout_s     = (cnt_q == CNT_LAST);
    fetch_flush_s = port.flush && (owner_q == OWN_IF);
    // A flush arriving in the very cycle of acceptance still kills the fetch.
    kill_now_s    = kill_q || fetch_flush_s;
  end

  // FSM next state, request latch, kill flag and timeout counter
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    kill_d   = kill_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    fire_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (port.dm_req_valid) begin
          owner_d     = OWN_DM;
          req_d.we    = port.dm_req_we;
          req_d.addr  = port.dm_req_addr;
          req_d.wdata = port.dm_req_wdata;
          req_d.be    = port.dm_req_be;
          state_d     = S_REQ;
        end else if (port.if_req_valid && !port.flush) begin
          owner_d     = OWN_IF;
          req_d.we    = 1'b0;
          req_d.addr  = port.if_req_addr;
          req_d.wdata = {XLEN{1'b0}};
          req_d.be    = {(XLEN/8){1'b1}};
          state_d     = S_REQ;
        end else begin
          state_d     = S_IDLE;
        end
      end
      S_REQ: begin
        if (port.bus_req_ready) begin
          cnt_d  = CNT_ZERO;
          kill_d = 1'b0;
          if (kill_now_s) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          kill_d  = kill_now_s;
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (port.bus_resp_valid || timeout_s) begin
          // A response landing in the flush cycle belongs to a dead fetch.
          fire_s  = !fetch_flush_s;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fetch_flush_s) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_DRAIN: begin
        if (port.bus_resp_valid || timeout_s) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    bus_req_valid_d = (state_d == S_REQ);
  end

  // Response steering: bus data passes straight through, timeout yields err/0
  always_comb begin
    if (rst) begin
      if_resp_valid_s = 1'b0;
      dm_resp_valid_s = 1'b0;
      resp_rdata_s    = {XLEN{1'b0}};
      resp_err_s      = 1'b0;
    end else begin
      if_resp_valid_s = fire_s && (owner_q == OWN_IF);
      dm_resp_valid_s = fire_s && (owner_q == OWN_DM);
      if (fire_s && port.bus_resp_valid) begin
        resp_rdata_s = port.bus_resp_rdata;
        resp_err_s   = port.bus_resp_err;
      end else if (fire_s) begin
        resp_rdata_s = {XLEN{1'b0}};
        resp_err_s   = 1'b1;
      end else begin
        resp_rdata_s = {XLEN{1'b0}};
        resp_err_s   = 1'b0;
      end
    end
  end

  // State, owner, kill flag, counter and request latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      owner_q         <= OWN_IF;
      kill_q          <= 1'b0;
      cnt_q           <= CNT_ZERO;
      req_q           <= REQ_ZERO;
      bus_req_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      kill_q          <= kill_d;
      cnt_q           <= cnt_d;
      req_q           <= req_d;
      bus_req_valid_q <= bus_req_valid_d;
    end
  end

  assign port.bus_req_valid = bus_req_valid_q;
  assign port.bus_req_we    = req_q.we;
  assign port.bus_req_addr  = req_q.addr;
  assign port.bus_req_wdata = req_q.wdata;
  assign port.bus_req_be    = req_q.be;

  assign port.if_resp_valid = if_resp_valid_s;
  assign port.if_resp_rdata = if_resp_valid_s ? resp_rdata_s : {XLEN{1'b0}};
  assign port.if_resp_err   = if_resp_valid_s && resp_err_s;
  assign port.dm_resp_valid = dm_resp_valid_s;
  assign port.dm_resp_rdata = dm_resp_valid_s ? resp_rdata_s : {XLEN{1'b0}};
  assign port.dm_resp_err   = dm_resp_valid_s && resp_err_s;

  assign port.if_stall = port.if_req_valid && !if_resp_valid_s;
  assign port.dm_stall = port.dm_req_valid && !dm_resp_valid_s;

endmodule
